pc_redirect_unit: RTL

//  IF-stage next-PC generator sitting directly upstream of branch_predict: owns pcF (which indexes the PHT).

---
 rtl/pc_redirect_if.sv | 35 +++
 rtl/pc_redirect_unit.sv | 80 ++++++++
 2 files changed

// File: rtl/pc_redirect_if.sv
// pc_redirect_if: fetch-redirect bundle between the pipeline control and pc_redirect_unit
//   master: pipeline side, drives stalls, flushes, D-stage branch/jump info and the E-stage mispredict
//   slave : pc_redirect_unit, returns pcF, pc_nextF, mispredict_flush and the performance counters
interface pc_redirect_if #(
    parameter int CNT_W = 32
);
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             flushE;
    logic             branchD;
    logic             jumpD;
    logic             pred_takeD;
    logic [31:0]      pcD;
    logic [31:0]      branch_targetD;
    logic [31:0]      jump_targetD;
    logic             preErrorE;
    logic [31:0]      pcF;
    logic [31:0]      pc_nextF;
    logic             mispredict_flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output stallF, stallD, stallE, flushE, branchD, jumpD, pred_takeD,
               pcD, branch_targetD, jump_targetD, preErrorE,
        input  pcF, pc_nextF, mispredict_flush, branch_cnt, mispred_cnt
    );

    modport slave (
        input  stallF, stallD, stallE, flushE, branchD, jumpD, pred_takeD,
               pcD, branch_targetD, jump_targetD, preErrorE,
        output pcF, pc_nextF, mispredict_flush, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage next-PC generator with D-stage redirect and E-stage mispredict recovery
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : pc_redirect_if.slave (stalls/flush, D-stage branch/jump info, E-stage preErrorE in;
//          pcF, pc_nextF, mispredict_flush, branch_cnt, mispred_cnt out)
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int          CNT_W      = 32
) (
    input logic               clk,
    input logic               rst,
    pc_redirect_if.slave      bus
);
    logic [31:0]      pcF;
    logic [31:0]      altPcE;
    logic [31:0]      pendPc;
    logic             validE;
    logic             pend;
    logic [CNT_W-1:0] branchCnt;
    logic [CNT_W-1:0] mispredCnt;
    logic [31:0]      fall;
    logic [31:0]      altPcD;
    logic [31:0]      pcNext;
    logic             errE;
    logic             flush;

    // The alternate path is whichever way the prediction did not go.
    assign fall   = bus.pcD + (DELAY_SLOT ? 32'd8 : 32'd4);
    assign altPcD = bus.pred_takeD ? fall : bus.branch_targetD;
    assign errE   = bus.preErrorE & validE;
    assign flush  = ~bus.stallF & (errE | pend);

    always_comb begin
        pcNext = errE           ? altPcE :
                 pend           ? pendPc :
                 bus.jumpD      ? bus.jump_targetD :
                 bus.pred_takeD ? bus.branch_targetD :
                                  pcF + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcF        <= RESET_PC;
            validE     <= 1'b0;
            altPcE     <= '0;
            pend       <= 1'b0;
            pendPc     <= '0;
            branchCnt  <= '0;
            mispredCnt <= '0;
        end else begin
            if (!bus.stallF) pcF <= pcNext;
            if (bus.flushE) begin
                validE <= 1'b0;
            end else if (!bus.stallE) begin
                if (bus.stallD) begin
                    validE <= 1'b0;
                end else begin
                    validE <= bus.branchD;
                    altPcE <= altPcD;
                end
            end
            // A recovery that arrives while fetch is stalled is parked until fetch moves.
            if (errE && bus.stallF) begin
                pend   <= 1'b1;
                pendPc <= altPcE;
            end else if (!bus.stallF) begin
                pend <= 1'b0;
            end
            if (!bus.stallE && validE) branchCnt <= branchCnt + 1'b1;
            if (flush) mispredCnt <= mispredCnt + 1'b1;
        end
    end

    assign bus.pcF              = pcF;
    assign bus.pc_nextF         = pcNext;
    assign bus.mispredict_flush = flush;
    assign bus.branch_cnt       = branchCnt;
    assign bus.mispred_cnt      = mispredCnt;
endmodule
